// File: rtl/nf_i_fu_pf.sv
// -----------------------------------------------------------------------------
// nf_i_fu_pf -- instruction fetch unit with prefetch buffer
//
// Generates sequential fetch addresses toward instruction memory over a
// req/ack handshake, buffers returned words together with their PC in a small
// FIFO and presents the FIFO head to decode. Branch redirects from the branch
// unit flush the buffer and retarget fetching. A redirect that lands while a
// request is still waiting for its ack must not move addr_i, so the FSM parks
// in DROP until that stale ack arrives and discards the word.
//
// Parameters
//   RESET_PC   first fetch address after reset
//   DEPTH      prefetch FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   addr_i, req_i        fetch address / request toward memory
//   req_ack_i, rd_i      memory acknowledge and read word (same cycle)
//   pc_src, branch_pc    redirect pulse and target from the branch unit
//   stall_if             decode not ready
//   instr_if, pc_if      instruction and its PC toward decode
//   valid_if             instr_if/pc_if carry a real instruction
// -----------------------------------------------------------------------------
module nf_i_fu_pf #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] addr_i,
    output logic        req_i,
    input  logic        req_ack_i,
    input  logic [31:0] rd_i,
    input  logic        pc_src,
    input  logic [31:0] branch_pc,
    input  logic        stall_if,
    output logic [31:0] instr_if,
    output logic [31:0] pc_if,
    output logic        valid_if
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // addi x0,x0,0 -- shown to decode whenever the buffer is empty
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [1:0]       state_q,    state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      drop_pc_q,  drop_pc_d;
    logic [31:0]      last_pc_q,  last_pc_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;

    logic [31:0] fifo_pc_q    [DEPTH];
    logic [31:0] fifo_instr_q [DEPTH];

    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [31:0] head_pc;
    logic [31:0] head_instr;

    // ------------------------------------------------------------------
    // Memory-side request. count can only shrink while a request waits,
    // so once req_i rises it stays up (with a fixed addr_i) until acked.
    // ------------------------------------------------------------------
    assign fifo_full = (count_q == CNT_W'(DEPTH));
    assign req_i     = ((state_q == ST_RUN) && !fifo_full) || (state_q == ST_DROP);
    assign addr_i    = (state_q == ST_DROP) ? drop_pc_q : fetch_pc_q;

    // A word is kept only in RUN; the same-cycle redirect makes it stale.
    assign push = (state_q == ST_RUN) && req_i && req_ack_i && !pc_src;

    // ------------------------------------------------------------------
    // Decode-side view
    // ------------------------------------------------------------------
    assign head_pc    = fifo_pc_q[rd_ptr_q];
    assign head_instr = fifo_instr_q[rd_ptr_q];

    assign valid_if = (count_q != '0);
    assign pop      = valid_if && !stall_if;
    assign instr_if = valid_if ? head_instr : NOP_INSTR;
    assign pc_if    = valid_if ? head_pc    : last_pc_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_pc_d  = drop_pc_q;
        last_pc_d  = last_pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        // Remember what decode consumed so pc_if stays meaningful when empty.
        if (pop) begin
            last_pc_d = head_pc;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end

            ST_RUN: begin
                if (pc_src) begin
                    fetch_pc_d = branch_pc;
                    count_d    = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    // addr_i must not change under a waiting request, so the
                    // stale address is parked and its ack drained in DROP.
                    if (req_i && !req_ack_i) begin
                        drop_pc_d = addr_i;
                        state_d   = ST_DROP;
                    end
                end else begin
                    if (push) begin
                        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                    case ({push, pop})
                        2'b10:   count_d = count_q + CNT_W'(1);
                        2'b01:   count_d = count_q - CNT_W'(1);
                        default: count_d = count_q;
                    endcase
                end
            end

            ST_DROP: begin
                // The buffer is already empty here; a new redirect only
                // retargets, the parked request still has to drain.
                if (pc_src) begin
                    fetch_pc_d = branch_pc;
                    count_d    = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                end else if (req_ack_i) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            drop_pc_q  <= RESET_PC;
            last_pc_q  <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_pc_q  <= drop_pc_d;
            last_pc_q  <= last_pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Prefetch storage. Contents need no reset: count_q gates visibility.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= fetch_pc_q;
            fifo_instr_q[wr_ptr_q] <= rd_i;
        end
    end

endmodule

// File: tb/tb_nf_i_fu_pf.sv
// -----------------------------------------------------------------------------
// tb_nf_i_fu_pf -- self-checking bench for nf_i_fu_pf
//
// A behavioural memory answers requests after a programmable latency with
// word = address and pushes every word that decode should eventually see
// into a scoreboard; words the scenario knows are abandoned by a redirect are
// flagged and not pushed. A negedge monitor pops the scoreboard on each
// delivered instruction. Scenario tasks add inline timing/address checks.
// -----------------------------------------------------------------------------
module tb_nf_i_fu_pf;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_i;
    logic        req_i;
    logic        req_ack_i;
    logic [31:0] rd_i;
    logic        pc_src;
    logic [31:0] branch_pc;
    logic        stall_if;
    logic [31:0] instr_if;
    logic [31:0] pc_if;
    logic        valid_if;

    always #5 clk = ~clk;

    nf_i_fu_pf #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr_i    (addr_i),
        .req_i     (req_i),
        .req_ack_i (req_ack_i),
        .rd_i      (rd_i),
        .pc_src    (pc_src),
        .branch_pc (branch_pc),
        .stall_if  (stall_if),
        .instr_if  (instr_if),
        .pc_if     (pc_if),
        .valid_if  (valid_if)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] sb[$];            // {pc, instr} expected at decode
    logic [63:0] mon_e;
    logic [31:0] last_pop_pc = RESET_PC;

    int mem_lat      = 0;
    int mem_cnt      = 0;
    bit mem_en       = 1'b0;
    bit mem_force    = 1'b0;       // ack regardless of req (late-ack test)
    bit drop_pending = 1'b0;       // next ack belongs to an abandoned fetch

    // ------------------------------------------------------------------
    // Memory model: updates 2 time units after each rising edge
    // ------------------------------------------------------------------
    initial begin
        req_ack_i = 1'b0;
        rd_i      = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_force) begin
                req_ack_i = 1'b1;
                rd_i      = 32'hDEAD_BEEF;
                mem_cnt   = 0;
            end else if (mem_en && req_i && !rst) begin
                if (mem_cnt >= mem_lat) begin
                    req_ack_i = 1'b1;
                    rd_i      = addr_i;
                    mem_cnt   = 0;
                    if (drop_pending) drop_pending = 1'b0;
                    else              sb.push_back({addr_i, addr_i});
                end else begin
                    req_ack_i = 1'b0;
                    rd_i      = 32'h0;
                    mem_cnt   = mem_cnt + 1;
                end
            end else begin
                req_ack_i = 1'b0;
                rd_i      = 32'h0;
                mem_cnt   = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard monitor: one line per delivered instruction
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst && valid_if && !stall_if) begin
            n_cmp = n_cmp + 1;
            if (sb.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL deliver_extra: got pc=%h instr=%h, required no delivery", pc_if, instr_if);
            end else begin
                mon_e = sb.pop_front();
                last_pop_pc = mon_e[63:32];
                if ({pc_if, instr_if} !== mon_e) begin
                    n_err = n_err + 1;
                    $display("FAIL deliver: got pc=%h instr=%h, required pc=%h instr=%h",
                             pc_if, instr_if, mon_e[63:32], mon_e[31:0]);
                end else begin
                    $display("deliver: pc=%h instr=%h", pc_if, instr_if);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run, required finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        mem_en       = 1'b0;
        mem_force    = 1'b0;
        drop_pending = 1'b0;
        pc_src       = 1'b0;
        stall_if     = 1'b0;
        rst          = 1'b1;
        last_pop_pc  = RESET_PC;
        tick;
        tick;
    endtask

    task automatic test_reset;
        tick;
        tick;
        n_cmp++; if (req_i !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b, required 0", req_i); end
        n_cmp++; if (addr_i !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h, required %h", addr_i, RESET_PC); end
        n_cmp++; if (valid_if !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, required 0", valid_if); end
        n_cmp++; if (instr_if !== NOP) begin n_err++; $display("FAIL reset_instr: got %h, required %h", instr_if, NOP); end
        n_cmp++; if (pc_if !== RESET_PC) begin n_err++; $display("FAIL reset_pc: got %h, required %h", pc_if, RESET_PC); end
    endtask

    // Drain the buffer with memory idle, then decode must see a NOP at the last PC.
    task automatic test_drain(input string tag);
        mem_en   = 1'b0;
        stall_if = 1'b0;
        pc_src   = 1'b0;
        repeat (2 * DEPTH + 3) tick;
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL %s_missing: got %0d undelivered, required 0", tag, sb.size()); end
        n_cmp++; if ({valid_if, instr_if} !== {1'b0, NOP}) begin n_err++; $display("FAIL %s_idle: got valid=%b instr=%h, required valid=0 instr=%h", tag, valid_if, instr_if, NOP); end
        n_cmp++; if (pc_if !== last_pop_pc) begin n_err++; $display("FAIL %s_lastpc: got %h, required %h", tag, pc_if, last_pop_pc); end
    endtask

    task automatic test_stream;
        mem_lat = 0;
        mem_en  = 1'b1;
        rst     = 1'b0;
        tick;
        n_cmp++; if ({req_i, addr_i} !== {1'b1, RESET_PC}) begin n_err++; $display("FAIL first_req: got req=%b addr=%h, required req=1 addr=%h", req_i, addr_i, RESET_PC); end
        n_cmp++; if (valid_if !== 1'b0) begin n_err++; $display("FAIL first_latency: got valid=%b, required 0", valid_if); end
        for (int i = 1; i < 8; i++) begin
            tick;
            n_cmp++; if (addr_i !== 32'(4 * i)) begin n_err++; $display("FAIL stream_addr: got %h, required %h", addr_i, 32'(4 * i)); end
            n_cmp++; if ({valid_if, pc_if} !== {1'b1, 32'(4 * (i - 1))}) begin n_err++; $display("FAIL stream_rate: got valid=%b pc=%h, required valid=1 pc=%h", valid_if, pc_if, 32'(4 * (i - 1))); end
        end
    endtask

    task automatic test_backpressure;
        stall_if = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            n_cmp++; if (req_i !== 1'b0) begin n_err++; $display("FAIL bp_req: got %b, required 0", req_i); end
            n_cmp++; if ({valid_if, pc_if, instr_if} !== {1'b1, 32'd24, 32'd24}) begin n_err++; $display("FAIL bp_hold: got valid=%b pc=%h instr=%h, required valid=1 pc=18 instr=18", valid_if, pc_if, instr_if); end
        end
        stall_if = 1'b0;
        tick;
        n_cmp++; if ({req_i, addr_i} !== {1'b1, 32'd32}) begin n_err++; $display("FAIL bp_resume: got req=%b addr=%h, required req=1 addr=20", req_i, addr_i); end
        n_cmp++; if ({valid_if, pc_if} !== {1'b1, 32'd28}) begin n_err++; $display("FAIL bp_order: got valid=%b pc=%h, required valid=1 pc=1c", valid_if, pc_if); end
        repeat (3) tick;
        test_drain("bp");
    endtask

    task automatic test_redirect_inflight;
        mem_lat = 3;
        mem_en  = 1'b1;
        rst     = 1'b0;
        tick;
        tick;
        pc_src       = 1'b1;
        branch_pc    = 32'h0000_0100;
        drop_pending = 1'b1;
        tick;
        pc_src    = 1'b0;
        branch_pc = 32'h0000_BAD0;
        n_cmp++; if ({req_i, addr_i} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL infl_hold1: got req=%b addr=%h, required req=1 addr=0", req_i, addr_i); end
        n_cmp++; if (valid_if !== 1'b0) begin n_err++; $display("FAIL infl_valid: got %b, required 0", valid_if); end
        tick;
        n_cmp++; if ({req_i, addr_i} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL infl_hold2: got req=%b addr=%h, required req=1 addr=0", req_i, addr_i); end
        tick;
        n_cmp++; if ({req_i, addr_i} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL infl_target: got req=%b addr=%h, required req=1 addr=100", req_i, addr_i); end
        for (int k = 0; k < 10 && valid_if !== 1'b1; k++) tick;
        n_cmp++; if ({valid_if, pc_if} !== {1'b1, 32'h100}) begin n_err++; $display("FAIL infl_first: got valid=%b pc=%h, required valid=1 pc=100", valid_if, pc_if); end
        test_drain("infl");
    endtask

    task automatic test_redirect_ack_pop;
        mem_lat = 0;
        mem_en  = 1'b1;
        rst     = 1'b0;
        tick;
        tick;
        pc_src       = 1'b1;
        branch_pc    = 32'h0000_0040;
        drop_pending = 1'b1;
        tick;
        pc_src = 1'b0;
        n_cmp++; if ({valid_if, instr_if, pc_if} !== {1'b0, NOP, 32'h0}) begin n_err++; $display("FAIL ackpop_flush: got valid=%b instr=%h pc=%h, required valid=0 instr=13 pc=0", valid_if, instr_if, pc_if); end
        n_cmp++; if ({req_i, addr_i} !== {1'b1, 32'h40}) begin n_err++; $display("FAIL ackpop_req: got req=%b addr=%h, required req=1 addr=40", req_i, addr_i); end
        tick;
        n_cmp++; if ({valid_if, pc_if} !== {1'b1, 32'h40}) begin n_err++; $display("FAIL ackpop_first: got valid=%b pc=%h, required valid=1 pc=40", valid_if, pc_if); end
        test_drain("ackpop");
    endtask

    task automatic test_double_redirect;
        mem_lat = 3;
        mem_en  = 1'b1;
        rst     = 1'b0;
        tick;
        tick;
        pc_src       = 1'b1;
        branch_pc    = 32'h0000_0200;
        drop_pending = 1'b1;
        tick;
        branch_pc = 32'h0000_0300;
        tick;
        pc_src = 1'b0;
        n_cmp++; if ({req_i, addr_i} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL dbl_hold: got req=%b addr=%h, required req=1 addr=0", req_i, addr_i); end
        tick;
        n_cmp++; if ({req_i, addr_i} !== {1'b1, 32'h300}) begin n_err++; $display("FAIL dbl_target: got req=%b addr=%h, required req=1 addr=300", req_i, addr_i); end
        for (int k = 0; k < 10 && valid_if !== 1'b1; k++) tick;
        n_cmp++; if ({valid_if, pc_if} !== {1'b1, 32'h300}) begin n_err++; $display("FAIL dbl_first: got valid=%b pc=%h, required valid=1 pc=300", valid_if, pc_if); end
        test_drain("dbl");
    endtask

    task automatic test_wrap_reset;
        mem_lat = 0;
        mem_en  = 1'b1;
        rst     = 1'b0;
        tick;
        pc_src       = 1'b1;
        branch_pc    = 32'hFFFF_FFFC;
        drop_pending = 1'b1;
        tick;
        pc_src = 1'b0;
        n_cmp++; if ({req_i, addr_i} !== {1'b1, 32'hFFFF_FFFC}) begin n_err++; $display("FAIL wrap_target: got req=%b addr=%h, required req=1 addr=fffffffc", req_i, addr_i); end
        tick;
        n_cmp++; if (addr_i !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h, required 0", addr_i); end
        n_cmp++; if ({valid_if, pc_if} !== {1'b1, 32'hFFFF_FFFC}) begin n_err++; $display("FAIL wrap_pc: got valid=%b pc=%h, required valid=1 pc=fffffffc", valid_if, pc_if); end
        mem_en = 1'b0;
        tick;
        n_cmp++; if (req_i !== 1'b1) begin n_err++; $display("FAIL mid_pending: got req=%b, required 1", req_i); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({req_i, valid_if} !== 2'b00) begin n_err++; $display("FAIL mid_rst_ctrl: got req=%b valid=%b, required 0 0", req_i, valid_if); end
        n_cmp++; if ({instr_if, pc_if, addr_i} !== {NOP, RESET_PC, RESET_PC}) begin n_err++; $display("FAIL mid_rst_data: got instr=%h pc=%h addr=%h, required 13 0 0", instr_if, pc_if, addr_i); end
        tick;
        rst       = 1'b0;
        mem_force = 1'b1;
        tick;
        mem_force = 1'b0;
        mem_en    = 1'b1;
        n_cmp++; if (valid_if !== 1'b0) begin n_err++; $display("FAIL late_ack: got valid=%b, required 0", valid_if); end
        n_cmp++; if ({req_i, addr_i} !== {1'b1, RESET_PC}) begin n_err++; $display("FAIL restart_req: got req=%b addr=%h, required req=1 addr=0", req_i, addr_i); end
        tick;
        n_cmp++; if ({valid_if, pc_if, instr_if} !== {1'b1, RESET_PC, RESET_PC}) begin n_err++; $display("FAIL restart_first: got valid=%b pc=%h instr=%h, required valid=1 pc=0 instr=0", valid_if, pc_if, instr_if); end
        test_drain("wrap");
    endtask

    initial begin
        rst       = 1'b1;
        pc_src    = 1'b0;
        branch_pc = 32'h0;
        stall_if  = 1'b0;

        test_reset;
        test_stream;
        test_backpressure;
        do_reset;
        test_redirect_inflight;
        do_reset;
        test_redirect_ack_pop;
        do_reset;
        test_double_redirect;
        do_reset;
        test_wrap_reset;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
